// File: rtl/lbdr_route_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lbdr_route_ctrl_pkg
// Shared constants and types for the LBDR route-computation unit.
//   - flit type encodings (HEADER / BODY / TAIL)
//   - default address width
//   - deroute port encodings
//   - bit indices into the Rxy / Cx vectors and the one-hot port vector
//   - FSM state encodings
//   - configuration bundle type (Rxy, Cx, dr)
// ---------------------------------------------------------------------------
package lbdr_route_ctrl_pkg;

    localparam int AXIS_DEF = 4;

    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] BODY   = 3'b010;
    localparam logic [2:0] TAIL   = 3'b100;

    // Deroute port encodings; they coincide with the Cx bit indices and the
    // low four bits of the one-hot port vector, so dr can index all three.
    localparam logic [1:0] DR_N = 2'd0;
    localparam logic [1:0] DR_E = 2'd1;
    localparam logic [1:0] DR_W = 2'd2;
    localparam logic [1:0] DR_S = 2'd3;

    // Rxy bit indices
    localparam int R_NE = 0;
    localparam int R_NW = 1;
    localparam int R_EN = 2;
    localparam int R_ES = 3;
    localparam int R_WN = 4;
    localparam int R_WS = 5;
    localparam int R_SE = 6;
    localparam int R_SW = 7;

    // Cx bit indices
    localparam int C_N = 0;
    localparam int C_E = 1;
    localparam int C_W = 2;
    localparam int C_S = 3;

    // One-hot port vector bit indices
    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_W = 2;
    localparam int P_S = 3;
    localparam int P_L = 4;

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic [7:0] rxy;
        logic [3:0] cx;
        logic [1:0] dr;
    } lbdr_cfg_t;

endpackage

// File: rtl/lbdr_route_ctrl_comb.sv
// ---------------------------------------------------------------------------
// lbdr_route_ctrl_comb
// Purely combinational LBDR route computation: coordinate comparators,
// minimal-path candidates, N>E>W>S priority with local override, and the
// single-port deroute fallback.
// Ports:
//   i_cur_addr  router address (x low half, y high half)
//   i_dst_addr  destination address of the head flit
//   i_cfg       current Rxy / Cx / dr configuration
//   o_sel       one-hot selected port {L,S,W,E,N}, all zero on error
//   o_err       no legal port exists
// ---------------------------------------------------------------------------
module lbdr_route_ctrl_comb
    import lbdr_route_ctrl_pkg::*;
#(
    parameter int AXIS       = AXIS_DEF,
    parameter bit DEROUTE_EN = 1'b1
) (
    input  logic [AXIS-1:0] i_cur_addr,
    input  logic [AXIS-1:0] i_dst_addr,
    input  lbdr_cfg_t       i_cfg,
    output logic [4:0]      o_sel,
    output logic            o_err
);

    localparam int H = AXIS / 2;

    logic [H-1:0] w_x_cur, w_y_cur, w_x_dst, w_y_dst;
    logic         w_n1, w_e1, w_w1, w_s1;
    logic         w_cand_n, w_cand_e, w_cand_w, w_cand_s, w_cand_l;

    assign w_x_cur = i_cur_addr[H-1:0];
    assign w_y_cur = i_cur_addr[AXIS-1:H];
    assign w_x_dst = i_dst_addr[H-1:0];
    assign w_y_dst = i_dst_addr[AXIS-1:H];

    assign w_n1 = w_y_dst < w_y_cur;
    assign w_s1 = w_y_cur < w_y_dst;
    assign w_e1 = w_x_cur < w_x_dst;
    assign w_w1 = w_x_dst < w_x_cur;

    assign w_cand_n = ((w_n1 & ~w_e1 & ~w_w1) | (w_n1 & w_e1 & i_cfg.rxy[R_NE])
                     | (w_n1 & w_w1 & i_cfg.rxy[R_NW])) & i_cfg.cx[C_N];
    assign w_cand_e = ((w_e1 & ~w_n1 & ~w_s1) | (w_e1 & w_n1 & i_cfg.rxy[R_EN])
                     | (w_e1 & w_s1 & i_cfg.rxy[R_ES])) & i_cfg.cx[C_E];
    assign w_cand_w = ((w_w1 & ~w_n1 & ~w_s1) | (w_w1 & w_n1 & i_cfg.rxy[R_WN])
                     | (w_w1 & w_s1 & i_cfg.rxy[R_WS])) & i_cfg.cx[C_W];
    assign w_cand_s = ((w_s1 & ~w_e1 & ~w_w1) | (w_s1 & w_e1 & i_cfg.rxy[R_SE])
                     | (w_s1 & w_w1 & i_cfg.rxy[R_SW])) & i_cfg.cx[C_S];
    assign w_cand_l = ~w_n1 & ~w_e1 & ~w_w1 & ~w_s1;

    // NOTE: every output gets a default before the if-chain so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_sel = '0;
        o_err = 1'b0;
        if (w_cand_l)       o_sel[P_L] = 1'b1;
        else if (w_cand_n)  o_sel[P_N] = 1'b1;
        else if (w_cand_e)  o_sel[P_E] = 1'b1;
        else if (w_cand_w)  o_sel[P_W] = 1'b1;
        else if (w_cand_s)  o_sel[P_S] = 1'b1;
        else if (DEROUTE_EN && i_cfg.cx[i_cfg.dr])
            o_sel[i_cfg.dr] = 1'b1;   // dr encoding matches the port bit index
        else
            o_err = 1'b1;
    end

endmodule

// File: rtl/lbdr_route_ctrl.sv
// ---------------------------------------------------------------------------
// lbdr_route_ctrl
// LBDR route-computation unit for one router input port. Routes each packet
// header to one registered one-hot output request and holds it until the
// tail is granted. Configuration writes during a packet are deferred to the
// packet boundary.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   Rxy_rst, Cx_rst, dr_rst       configuration loaded during reset
//   cur_addr_rst                  router address, loaded during reset
//   cfg_we, cfg_Rxy/Cx/dr         run-time configuration write
//   empty, flit_type, dst_addr    head-of-FIFO status
//   grant                         head flit consumed this cycle
//   Nport..Lport                  registered one-hot output request
//   route_err                     registered: head header has no legal port,
//                                 non-header in IDLE, or header missing a tail
// ---------------------------------------------------------------------------
module lbdr_route_ctrl
    import lbdr_route_ctrl_pkg::*;
#(
    parameter int AXIS       = AXIS_DEF,
    parameter bit DEROUTE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      Rxy_rst,
    input  logic [3:0]      Cx_rst,
    input  logic [1:0]      dr_rst,
    input  logic [AXIS-1:0] cur_addr_rst,
    input  logic            cfg_we,
    input  logic [7:0]      cfg_Rxy,
    input  logic [3:0]      cfg_Cx,
    input  logic [1:0]      cfg_dr,
    input  logic            empty,
    input  logic [2:0]      flit_type,
    input  logic [AXIS-1:0] dst_addr,
    input  logic            grant,
    output logic            Nport,
    output logic            Eport,
    output logic            Wport,
    output logic            Sport,
    output logic            Lport,
    output logic            route_err
);

    lbdr_cfg_t       r_cfg;
    lbdr_cfg_t       r_cfg_pend;
    logic            r_pend_vld;
    logic [AXIS-1:0] r_cur_addr;
    logic [0:0]      r_state;
    logic [4:0]      r_port;
    logic            r_err;
    // The routed header may still sit at the FIFO head for a few cycles after
    // routing; it must not be mistaken for a new header missing its tail.
    logic            r_hdr_at_head;

    lbdr_cfg_t  w_cfg_in;
    logic [4:0] w_sel;
    logic       w_sel_err;
    logic       w_is_hdr;
    logic       w_tail_grant;
    logic       w_new_hdr;
    logic       w_leave;

    assign w_cfg_in     = '{rxy: cfg_Rxy, cx: cfg_Cx, dr: cfg_dr};
    assign w_is_hdr     = !empty && (flit_type == HEADER);
    assign w_tail_grant = grant && !empty && (flit_type == TAIL);
    assign w_new_hdr    = w_is_hdr && !r_hdr_at_head;
    // Leaving HOLD is a packet boundary: either the tail was granted or a
    // missing-tail header could not be routed.
    assign w_leave      = (r_state == ST_HOLD)
                        && (w_tail_grant || (w_new_hdr && w_sel_err));

    lbdr_route_ctrl_comb #(
        .AXIS       (AXIS),
        .DEROUTE_EN (DEROUTE_EN)
    ) u_comb (
        .i_cur_addr (r_cur_addr),
        .i_dst_addr (dst_addr),
        .i_cfg      (r_cfg),
        .o_sel      (w_sel),
        .o_err      (w_sel_err)
    );

    // NOTE: all state updates here are non-blocking so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg         <= '{rxy: Rxy_rst, cx: Cx_rst, dr: dr_rst};
            r_cfg_pend    <= '0;
            r_pend_vld    <= 1'b0;
            r_cur_addr    <= cur_addr_rst;
            r_state       <= ST_IDLE;
            r_port        <= '0;
            r_err         <= 1'b0;
            r_hdr_at_head <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Header evaluated this cycle still sees the old r_cfg.
                    if (cfg_we) r_cfg <= w_cfg_in;
                    r_port <= '0;
                    r_err  <= 1'b0;
                    if (!empty) begin
                        if (flit_type != HEADER) begin
                            r_err <= 1'b1;
                        end else if (w_sel_err) begin
                            r_err <= 1'b1;
                        end else begin
                            r_port        <= w_sel;
                            r_state       <= ST_HOLD;
                            r_hdr_at_head <= ~grant;
                        end
                    end
                end

                ST_HOLD: begin
                    r_err <= 1'b0;
                    if (w_tail_grant) begin
                        r_port  <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_new_hdr) begin
                        // Missing tail: flag it and re-route immediately.
                        r_err         <= 1'b1;
                        r_hdr_at_head <= ~grant;
                        if (w_sel_err) begin
                            r_port  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_port  <= w_sel;
                        end
                    end else if (grant && !empty) begin
                        r_hdr_at_head <= 1'b0;
                    end

                    // Deferred configuration; a write in the boundary cycle
                    // itself is the most recent and wins.
                    if (w_leave) begin
                        if (cfg_we)          r_cfg <= w_cfg_in;
                        else if (r_pend_vld) r_cfg <= r_cfg_pend;
                        r_pend_vld <= 1'b0;
                    end else if (cfg_we) begin
                        r_cfg_pend <= w_cfg_in;
                        r_pend_vld <= 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Nport     = r_port[P_N];
    assign Eport     = r_port[P_E];
    assign Wport     = r_port[P_W];
    assign Sport     = r_port[P_S];
    assign Lport     = r_port[P_L];
    assign route_err = r_err;

endmodule

// File: doc/lbdr_route_ctrl.md
# lbdr_route_ctrl

Parametrised LBDR route-computation unit for one router input port, in front of the switch allocator. Supports all five output directions (N/E/W/S/L) and any square mesh address width. Adds per-packet route hold, priority one-hot selection, a single deroute port and run-time reconfiguration applied only at packet boundaries. It replaces the minimal East/South/Local unit used in the 2x2 mesh.

## Interface
Parameters:
- AXIS, 4: address width. x = low AXIS/2 bits, y = high AXIS/2 bits, both unsigned.
- DEROUTE_EN, 1: 1 enables the deroute fallback; 0 makes an unroutable header an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- Rxy_rst  in  8  routing bits loaded at reset: [0]Rne [1]Rnw [2]Ren [3]Res [4]Rwn [5]Rws [6]Rse [7]Rsw.
- Cx_rst  in  4  connectivity loaded at reset: [0]Cn [1]Ce [2]Cw [3]Cs.
- dr_rst  in  2  deroute port loaded at reset (0=N, 1=E, 2=W, 3=S).
- cur_addr_rst  in  AXIS  router address, loaded at reset only.
- cfg_we  in  1  run-time configuration write strobe.
- cfg_Rxy / cfg_Cx / cfg_dr  in  8/4/2  configuration write data.
- empty  in  1  input FIFO empty.
- flit_type  in  3  type of the head flit.
- dst_addr  in  AXIS  destination address of the head flit.
- grant  in  1  head flit consumed this cycle.
- Nport, Eport, Wport, Sport, Lport  out  1 each  registered one-hot output request.
- route_err  out  1  registered; no legal port exists for the header at the head.

## Operation
- Reset: while rst=1, Rxy/Cx/dr/cur_addr are loaded from the *_rst inputs. All port outputs and route_err go to 0, the pending-config flag clears, and FSM = IDLE. Reset mid-packet abandons the held route.
- Comparators: N1 = y_dst<y_cur, S1 = y_cur<y_dst, E1 = x_cur<x_dst, W1 = x_dst<x_cur.
- Minimal candidates:
  - N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw) & Cn
  - E = (E1&~N1&~S1 | E1&N1&Ren | E1&S1&Res) & Ce
  - W = (W1&~N1&~S1 | W1&N1&Rwn | W1&S1&Rws) & Cw
  - S = (S1&~E1&~W1 | S1&E1&Rse | S1&W1&Rsw) & Cs
  - L = ~N1&~E1&~W1&~S1
- Selection:
  - L overrides all. Otherwise priority N>E>W>S gives exactly one port.
  - If no candidate and DEROUTE_EN=1 and C[dr]=1, select port dr.
  - If there is still no port, it is an error: no port, route_err=1.
- FSM IDLE:
  - If !empty and flit_type==`HEADER, latch the selected port, go to HOLD, route_err=0.
  - If the selection is an error, stay in IDLE, route_err=1, and re-evaluate every cycle.
  - Non-header head flit in IDLE sets route_err=1; outputs stay 0.
- FSM HOLD:
  - Port output is held constant. empty=1 does not clear it.
  - grant & !empty & flit_type==`TAIL clears the outputs next cycle and returns to IDLE.
  - A `HEADER at the head while in HOLD (missing tail) sets route_err=1 for one cycle and re-routes from the new header with no idle cycle.
- Configuration:
  - cfg_we in IDLE: new Rxy/Cx/dr are used from the next cycle. A header evaluated in the same cycle uses the old values.
  - cfg_we in HOLD: the write is stored as pending and applied in the cycle after the tail grant. The last write wins.
  - The held port is never changed by configuration.

## Timing
- Header at head in cycle t: port valid at t+1.
- Tail grant at t: ports 0 at t+1. A back-to-back header present at t+1 is routed at t+2.
- route_err has the same one-cycle latency as the ports.
- No combinational path from inputs to outputs.

## Structure
- Shared parameters.v holds:
  - `HEADER=3'b001, `BODY=3'b010, `TAIL=3'b100
  - `AXIS default
  - deroute encodings DR_N/DR_E/DR_W/DR_S
  - Rxy/Cx bit-index constants
- Sub-module lbdr_route_comb: purely combinational comparators, candidate logic and priority/deroute selection. It outputs a 5-bit one-hot and an err bit.
- The top level holds the config registers, the pending-config register, the FSM and the output registers.

## Test plan
All scenarios use AXIS=4, cur_addr_rst=4'b0101 (x=1, y=1), Rxy_rst=8'hFF, Cx_rst=4'hF, dr_rst=1.
- Header dst=4'b0110, then BODY with empty=1 gaps, then TAIL with grant: Eport=1 from t+1 through the gaps, 0 the cycle after the tail grant.
- Header dst=4'b0101: Lport=1 only.
- Header dst=4'b0010 (x=2, y=0): Nport=1 only, since priority N beats E with both candidates set.
- Cx_rst=4'b1110, header dst=4'b0001 (due north): deroute gives Eport=1. Repeat with Cx_rst=4'b1100: no port, route_err=1 each cycle while the header waits.
- In HOLD on Eport, cfg_we with cfg_Cx=4'b1101: Eport stays held. After the tail, header dst=4'b0110 gives no E candidate (Ce=0) and deroutes to dr=1=E, also disconnected, so route_err=1. The same header before the write routes E.
- Header, body, second header with no tail: route_err pulses one cycle and the ports switch to the new route at the next cycle. rst asserted in HOLD: all outputs 0 the next cycle.
